// File: rtl/c_serial_adder.sv
// c_serial_adder: bit-serial add/subtract sequencer sharing one full-adder cell over WIDTH cycles, LSB first.
// Start/busy/done handshake; result, carry_out and overflow are held until the next accepted start.

module c_serial_adder_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module c_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_carry_out;
    logic             r_overflow;
    logic             w_sum;
    logic             w_cout;
    logic             w_last;

    c_serial_adder_fa u_fa (
        .i_a(r_op_a[0]),
        .i_b(r_op_b[0]),
        .i_c(r_carry),
        .o_s(w_sum),
        .o_c(w_cout)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            default: w_next = IDLE;
        endcase
    end

    // Counter holds at WIDTH-1 on the final step so it never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op_a      <= a;
                        r_op_b      <= sub ? ~b : b;
                        r_carry     <= sub;
                        r_cnt       <= '0;
                        r_result    <= '0;
                        r_carry_out <= 1'b0;
                        r_overflow  <= 1'b0;
                    end
                end
                RUN: begin
                    r_result <= {w_sum, r_result[WIDTH-1:1]};
                    r_op_a   <= {1'b0, r_op_a[WIDTH-1:1]};
                    r_op_b   <= {1'b0, r_op_b[WIDTH-1:1]};
                    r_carry  <= w_cout;
                    if (w_last) begin
                        r_carry_out <= w_cout;
                        r_overflow  <= r_carry ^ w_cout;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
endmodule

// File: tb/tb_c_serial_adder.sv
// tb_c_serial_adder: directed table-driven bench for the bit-serial adder with handshake and reset corner cases.
module tb_c_serial_adder;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] res;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[9];

    c_serial_adder #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .sub(sub),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .result(result),
        .carry_out(carry_out),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        int n_done;
        @(negedge clk);
        a = v.a;
        b = v.b;
        sub = v.sub;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        sub = ~sub;
        chk("busy_after_accept", 32'(busy), 32'd1);
        n_done = 0;
        for (int n = 1; n <= WIDTH + 4; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n_done = n;
                break;
            end
            if (!busy) chk("busy_during_run", 32'(busy), 32'd1);
        end
        chk("done_latency", 32'(n_done), 32'(WIDTH));
        chk("result", 32'(result), 32'(v.res));
        chk("carry_out", 32'(carry_out), 32'(v.cout));
        chk("overflow", 32'(overflow), 32'(v.ovf));
        @(posedge clk);
        #1;
        chk("idle_after_done", {30'd0, busy, done}, 32'd0);
        chk("result_held", 32'(result), 32'(v.res));
    endtask

    initial begin
        vecs[0] = '{16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[6] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{16'hAAAA, 16'h5555, 1'b1, 16'h5555, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {11'd0, busy, done, carry_out, overflow, result}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_op(vecs[i]);

        // start held high: mid-run operand change ignored, second op accepted only after DONE
        begin
            int d1;
            int d2;
            int npulse;
            logic [15:0] r1;
            logic [15:0] r2;
            logic        busy17;
            d1 = 0;
            d2 = 0;
            npulse = 0;
            r1 = '0;
            r2 = '0;
            busy17 = 1'b1;
            @(negedge clk);
            a = 16'h0003;
            b = 16'h0005;
            sub = 1'b0;
            start = 1'b1;
            @(posedge clk);
            for (int n = 1; n <= 40; n++) begin
                @(posedge clk);
                #1;
                if (n == 3) begin
                    a = 16'h1234;
                    b = 16'h1111;
                end
                if (n == 17) busy17 = busy;
                if (done) begin
                    npulse++;
                    if (npulse == 1) begin
                        d1 = n;
                        r1 = result;
                    end else begin
                        d2 = n;
                        r2 = result;
                    end
                end
            end
            start = 1'b0;
            chk("hs_first_done", 32'(d1), 32'd16);
            chk("hs_first_result", 32'(r1), 32'h0008);
            chk("hs_idle_gap", 32'(busy17), 32'd0);
            chk("hs_pulse_spacing", 32'(d2 - d1), 32'd18);
            chk("hs_second_result", 32'(r2), 32'h2345);
            chk("hs_pulse_count", 32'(npulse), 32'd2);
            repeat (WIDTH + 4) @(posedge clk);
        end

        // asynchronous reset six cycles into RUN
        begin
            int seen_done;
            seen_done = 0;
            @(negedge clk);
            a = 16'hFFFF;
            b = 16'h0001;
            sub = 1'b0;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (6) @(posedge clk);
            #3;
            reset = 1'b1;
            #1;
            chk("async_reset_clear", {11'd0, busy, done, carry_out, overflow, result}, 32'd0);
            for (int n = 0; n < 3; n++) begin
                @(posedge clk);
                #1;
                if (done) seen_done++;
            end
            @(negedge clk);
            reset = 1'b0;
            for (int n = 0; n < WIDTH + 4; n++) begin
                @(posedge clk);
                #1;
                if (done) seen_done++;
            end
            chk("no_done_after_abort", 32'(seen_done), 32'd0);
            run_op(vecs[6]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
